idelay_tap_emu: RTL and testbench
=================================

IDELAY_TAP_EMU -- requirements
Module: idelay_tap_emu

Interface
REQ-001 SHALL have parameter TAP_W, default 5, meaning tap-count width; delay line depth is 2**TAP_W.
REQ-002 SHALL have parameter TAP_INIT, default 0, meaning tap value loaded on reset.
REQ-003 SHALL have parameter RDY_CYCLES, default 16, meaning number of clk cycles after reset release before idly_rdy asserts (range 1..255).
REQ-004 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port: cntval_in  input  TAP_W  tap value to load.
REQ-007 SHALL have port: cntval_load  input  1  load strobe for cntval_in.
REQ-008 SHALL have port: ce  input  1  tap step enable.
REQ-009 SHALL have port: inc  input  1  step direction, 1 = increment, 0 = decrement; sampled only when ce=1.
REQ-010 SHALL have port: cntval_out  output  TAP_W  current tap value, registered.
REQ-011 SHALL have port: data_strobe_in  input  2  strobe samples entering the delay line.
REQ-012 SHALL have port: data_strobe_out  output  2  delayed strobe, registered.
REQ-013 SHALL have port: idly_rdy  output  1  delay element calibrated and accepting tap changes.
REQ-014 SHALL have port: tap_busy  output  1  one-cycle pulse on the cycle after any tap change.

Function
REQ-015 Ready counter SHALL count clk cycles from reset release; idly_rdy SHALL rise exactly RDY_CYCLES cycles after the first edge with rst=1, then stay high until reset.
REQ-016 While idly_rdy=0, cntval_load and ce SHALL be ignored; the tap SHALL hold TAP_INIT.
REQ-017 With idly_rdy=1 and cntval_load=1, the tap SHALL take cntval_in at that edge; cntval_out SHALL show it the following cycle.
REQ-018 With idly_rdy=1, cntval_load=0, ce=1, inc=1, the tap SHALL increment by 1, wrapping from 2**TAP_W-1 to 0.
REQ-019 With idly_rdy=1, cntval_load=0, ce=1, inc=0, the tap SHALL decrement by 1, wrapping from 0 to 2**TAP_W-1.
REQ-020 cntval_load SHALL take priority over ce when both are 1 in the same cycle.
REQ-021 A load of a value equal to the current tap SHALL NOT count as a tap change.
REQ-022 The delay line SHALL be a 2**TAP_W-deep shift register of 2-bit samples that shifts data_strobe_in in every cycle regardless of idly_rdy.
REQ-023 In steady state, data_strobe_out at cycle n SHALL equal data_strobe_in at cycle n-1-tap; tap=0 gives 1-cycle latency.
REQ-024 On the cycle after a tap change, tap_busy SHALL be 1 and data_strobe_out SHALL hold its previous value (settle freeze); normal tracking at the new tap SHALL resume the next cycle.
REQ-025 Back-to-back tap changes SHALL keep tap_busy high and data_strobe_out frozen for each cycle that follows a change.
REQ-026 The tap register SHALL never leave the range 0..2**TAP_W-1; all tap arithmetic SHALL be modulo 2**TAP_W.

Reset
REQ-027 While rst=0: tap and cntval_out = TAP_INIT, delay line = all zeros, data_strobe_out = 2'b00, idly_rdy = 0, tap_busy = 0, ready counter = 0.
REQ-028 Reset asserted mid-operation SHALL abort any tap change immediately, take effect asynchronously, and restart the ready count on release.
REQ-029 Reset release SHALL be treated as synchronous to clk; the first counted cycle is the first rising edge with rst=1.

Verification
REQ-030 Reset release, no other stimulus -> idly_rdy=0 for 16 cycles, 1 on cycle 16; cntval_out=0 throughout.
REQ-031 cntval_load=1, cntval_in=5'd7 at cycle 3 (before ready) -> cntval_out stays 0; the same load after ready -> cntval_out=7 next cycle, tap_busy pulses once.
REQ-032 tap=31, ce=1, inc=1 -> cntval_out=0; then ce=1, inc=0 -> cntval_out=31; cntval_load with cntval_in=5 plus ce=1, inc=1 in the same cycle -> cntval_out=5.
REQ-033 tap=10, single-cycle data_strobe_in=2'b11 pulse at cycle n -> data_strobe_out=2'b11 exactly at cycle n+11, 2'b00 elsewhere.
REQ-034 Strobe toggling every cycle, load tap 3 -> 4 -> data_strobe_out frozen for 1 cycle with tap_busy=1, then tracks at latency 5.
REQ-035 rst=0 asserted mid-stream with tap=20 -> all outputs reach reset values without a clock edge; idly_rdy reasserts 16 cycles after release.

Source files
------------

// File: rtl/idelay_tap_emu.sv
// Behavioural emulation of a tap-programmable input delay element: a 2-bit strobe
// delay line with a loadable/steppable tap, a calibration-ready delay and a settle freeze.
module idelay_tap_emu #(
    parameter int TAP_W      = 5,
    parameter int TAP_INIT   = 0,
    parameter int RDY_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAP_W-1:0] cntval_in,
    input  logic             cntval_load,
    input  logic             ce,
    input  logic             inc,
    output logic [TAP_W-1:0] cntval_out,
    input  logic [1:0]       data_strobe_in,
    output logic [1:0]       data_strobe_out,
    output logic             idly_rdy,
    output logic             tap_busy
);

    localparam int               DEPTH    = 2 ** TAP_W;
    localparam logic [TAP_W-1:0] TAP_RST  = TAP_W'(TAP_INIT);
    localparam logic [7:0]       RDY_LAST = 8'(RDY_CYCLES);

    logic [7:0]       rdy_cnt;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] tap_next;
    logic             tap_change;
    logic [1:0]       line [DEPTH];

    // Ready counter stops once it reaches RDY_CYCLES; idly_rdy rises on the following edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_cnt  <= 8'd0;
            idly_rdy <= 1'b0;
        end else if (!idly_rdy) begin
            if (rdy_cnt == RDY_LAST) idly_rdy <= 1'b1;
            else                     rdy_cnt  <= rdy_cnt + 8'd1;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        tap_next   = tap;
        tap_change = 1'b0;
        if (idly_rdy) begin
            if (cntval_load) begin
                tap_next   = cntval_in;
                tap_change = (cntval_in != tap);
            end else if (ce) begin
                tap_next   = inc ? tap + TAP_W'(1) : tap - TAP_W'(1);
                tap_change = 1'b1;
            end
        end
    end

    // NOTE: the delay line is reset explicitly because stale samples must not leak out after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= 2'b00;
        end else begin
            line[0] <= data_strobe_in;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    // Output holds for the settle cycle after any tap change, then follows the new tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap             <= TAP_RST;
            tap_busy        <= 1'b0;
            data_strobe_out <= 2'b00;
        end else begin
            tap      <= tap_next;
            tap_busy <= tap_change;
            if (!tap_change) data_strobe_out <= line[tap];
        end
    end

    assign cntval_out = tap;

endmodule

// File: tb/tb_idelay_tap_emu.sv
// Self-checking bench for idelay_tap_emu: directed steps plus randomized traffic,
// compared against a sample-history model of the delay element.
module tb_idelay_tap_emu;

    localparam int TAP_W      = 5;
    localparam int TAP_INIT   = 0;
    localparam int RDY_CYCLES = 16;
    localparam int DEPTH      = 2 ** TAP_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [TAP_W-1:0] cntval_in;
    logic             cntval_load;
    logic             ce;
    logic             inc;
    logic [TAP_W-1:0] cntval_out;
    logic [1:0]       data_strobe_in;
    logic [1:0]       data_strobe_out;
    logic             idly_rdy;
    logic             tap_busy;

    int checks   = 0;
    int failures = 0;

    // Model state: tap, ready, busy, expected output, and every sampled input since reset release.
    int         mtap;
    bit         mrdy;
    bit         mbusy;
    logic [1:0] mout;
    logic [1:0] hist[$];

    idelay_tap_emu #(
        .TAP_W      (TAP_W),
        .TAP_INIT   (TAP_INIT),
        .RDY_CYCLES (RDY_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cntval_in       (cntval_in),
        .cntval_load     (cntval_load),
        .ce              (ce),
        .inc             (inc),
        .cntval_out      (cntval_out),
        .data_strobe_in  (data_strobe_in),
        .data_strobe_out (data_strobe_out),
        .idly_rdy        (idly_rdy),
        .tap_busy        (tap_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/cntval_out"},      32'(cntval_out),      32'(mtap));
        check({tag, "/data_strobe_out"}, 32'(data_strobe_out), 32'(mout));
        check({tag, "/idly_rdy"},        32'(idly_rdy),        32'(mrdy));
        check({tag, "/tap_busy"},        32'(tap_busy),        32'(mbusy));
    endtask

    task automatic model_reset();
        mtap  = TAP_INIT;
        mrdy  = 1'b0;
        mbusy = 1'b0;
        mout  = 2'b00;
        hist.delete();
    endtask

    // One clock edge: update the model from the inputs the DUT samples, then check outputs.
    task automatic step(input string tag);
        int m;
        int nt;
        bit chg;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            chg = 1'b0;
            nt  = mtap;
            if (mrdy) begin
                if (cntval_load) begin
                    nt  = int'(cntval_in);
                    chg = (nt != mtap);
                end else if (ce) begin
                    nt  = inc ? (mtap + 1) % DEPTH : (mtap + DEPTH - 1) % DEPTH;
                    chg = 1'b1;
                end
            end
            m = hist.size();
            if (!chg) mout = (m - 1 - mtap >= 0) ? hist[m - 1 - mtap] : 2'b00;
            hist.push_back(data_strobe_in);
            mtap  = nt;
            mbusy = chg;
            mrdy  = (m >= RDY_CYCLES);
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        cntval_load = 1'b0;
        ce          = 1'b0;
        inc         = 1'b0;
        cntval_in   = '0;
    endtask

    task automatic load_tap(input int val, input string tag);
        cntval_load = 1'b1;
        cntval_in   = TAP_W'(val);
        step(tag);
        cntval_load = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        data_strobe_in = 2'b00;
        idle_inputs();
        model_reset();

        // Asynchronous reset from power-up, then a couple of edges held in reset.
        #2 rst = 1'b0;
        #1 check_all("por");
        step("in_reset0");
        step("in_reset1");

        // Release away from the edge; a load at edge 3 is ignored before ready.
        rst = 1'b1;
        for (int k = 0; k <= RDY_CYCLES; k++) begin
            if (k == 3) begin
                cntval_load = 1'b1;
                cntval_in   = 5'd7;
            end
            step("ready_wait");
            idle_inputs();
            if (k == RDY_CYCLES - 1) check("rdy_low_at15", 32'(idly_rdy), 32'd0);
            if (k == RDY_CYCLES)     check("rdy_high_at16", 32'(idly_rdy), 32'd1);
        end
        check("early_load_ignored", 32'(cntval_out), 32'd0);

        load_tap(7, "load7");
        check("load7_tap", 32'(cntval_out), 32'd7);
        check("load7_busy", 32'(tap_busy), 32'd1);
        step("load7_after");
        check("load7_busy_clear", 32'(tap_busy), 32'd0);

        // Wrap-around in both directions and load-over-ce priority.
        load_tap(31, "load31");
        ce = 1'b1; inc = 1'b1;
        step("inc_wrap");
        check("inc_wrap_tap", 32'(cntval_out), 32'd0);
        inc = 1'b0;
        step("dec_wrap");
        check("dec_wrap_tap", 32'(cntval_out), 32'd31);
        inc = 1'b1; cntval_load = 1'b1; cntval_in = 5'd5;
        step("load_prio");
        check("load_prio_tap", 32'(cntval_out), 32'd5);
        idle_inputs();
        load_tap(5, "load_same");
        check("load_same_busy", 32'(tap_busy), 32'd0);

        // Single strobe pulse through tap 10.
        load_tap(10, "load10");
        for (int k = 0; k < 40; k++) step("flush10");
        data_strobe_in = 2'b11;
        step("pulse_in");
        data_strobe_in = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            step("pulse_track");
            check("pulse_out", 32'(data_strobe_out), (k == 11) ? 32'd3 : 32'd0);
        end

        // Toggling strobe, retune tap 3 -> 4.
        load_tap(3, "load3");
        for (int k = 0; k < 40; k++) begin
            data_strobe_in = ~data_strobe_in;
            step("toggle3");
        end
        data_strobe_in = ~data_strobe_in;
        load_tap(4, "load4");
        check("retune_busy", 32'(tap_busy), 32'd1);
        for (int k = 0; k < 12; k++) begin
            data_strobe_in = ~data_strobe_in;
            step("toggle4");
        end

        // Back-to-back steps keep the output frozen.
        ce = 1'b1; inc = 1'b1;
        for (int k = 0; k < 4; k++) step("b2b_inc");
        idle_inputs();
        step("b2b_end");

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            data_strobe_in = 2'($urandom_range(0, 3));
            cntval_load    = ($urandom_range(0, 7) == 0);
            cntval_in      = TAP_W'($urandom_range(0, DEPTH - 1));
            ce             = ($urandom_range(0, 2) == 0);
            inc            = 1'($urandom_range(0, 1));
            step("random");
        end
        idle_inputs();

        // Mid-stream asynchronous reset at tap 20.
        load_tap(20, "load20");
        for (int k = 0; k < 40; k++) begin
            data_strobe_in = 2'($urandom_range(0, 3));
            step("stream20");
        end
        #3 rst = 1'b0;
        #1;
        check("async_tap",  32'(cntval_out),      32'(TAP_INIT));
        check("async_out",  32'(data_strobe_out), 32'd0);
        check("async_rdy",  32'(idly_rdy),        32'd0);
        check("async_busy", 32'(tap_busy),        32'd0);
        model_reset();
        step("reset_hold0");
        step("reset_hold1");
        rst = 1'b1;
        for (int k = 0; k <= RDY_CYCLES + 2; k++) begin
            data_strobe_in = 2'($urandom_range(0, 3));
            step("rerelease");
            if (k == RDY_CYCLES - 1) check("rerdy_low_at15", 32'(idly_rdy), 32'd0);
            if (k == RDY_CYCLES)     check("rerdy_high_at16", 32'(idly_rdy), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
